// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI transaction types and defaults
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    XFER,
    CAPTURE
  } spi_state_e;

  localparam logic [1:0] SLAVE_NONE    = 2'd0;
  localparam int         SPI_BYTE_W    = 8;
  localparam int         SPI_BITS_DEF  = 8;
  localparam int         SPI_GUARD_DEF = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   grant_o,
  output logic            valid_o
);

  int idx;

  // Scan from farthest to nearest so the closest set bit to ptr wins.
  always_comb begin
    grant_o = ptr_i;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) begin
        grant_o = IW'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - shares one SPI master among NREQ requesters, one byte per grant
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int BITS  = SPI_BITS_DEF,
  parameter int GUARD = SPI_GUARD_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [2*NREQ-1:0]          req_slave,
  input  logic [SPI_BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            err,
  output logic [SPI_BYTE_W-1:0]      rsp_data,
  output logic                       busy,
  output logic                       spi_start,
  output logic [1:0]                 spi_slave_select,
  output logic [SPI_BYTE_W-1:0]      spi_tx_data,
  input  logic [SPI_BYTE_W-1:0]      spi_rx_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BITS + GUARD) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS + GUARD - 1);

  spi_state_e            state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         gnt_q;
  logic [CW-1:0]         cnt_q;
  logic [NREQ-1:0]       done_q;
  logic [NREQ-1:0]       err_q;
  logic [SPI_BYTE_W-1:0] rsp_q;
  logic                  start_q;
  logic [1:0]            sel_q;
  logic [SPI_BYTE_W-1:0] tx_q;

  logic [IW-1:0]         arb_gnt;
  logic                  arb_valid;
  logic [1:0]            slave_arr [NREQ];
  logic [SPI_BYTE_W-1:0] data_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign slave_arr[i] = req_slave[2*i +: 2];
    assign data_arr[i]  = req_data[SPI_BYTE_W*i +: SPI_BYTE_W];
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt),
    .valid_o (arb_valid)
  );

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
    return (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // While done/err is still pulsing the requester has not yet seen it, so its
  // req level is stale; arbitration waits one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rsp_q   <= '0;
      start_q <= 1'b0;
      sel_q   <= '0;
      tx_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid && (done_q == '0) && (err_q == '0)) begin
            gnt_q <= arb_gnt;
            if (slave_arr[arb_gnt] == SLAVE_NONE) begin
              err_q <= NREQ'(1) << arb_gnt;
              ptr_q <= ptr_after(arb_gnt);
            end else begin
              sel_q   <= slave_arr[arb_gnt];
              tx_q    <= data_arr[arb_gnt];
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= XFER;
        end
        XFER: begin
          if (cnt_q == CNT_LAST) state_q <= CAPTURE;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        CAPTURE: begin
          rsp_q   <= spi_rx_data;
          done_q  <= NREQ'(1) << gnt_q;
          ptr_q   <= ptr_after(gnt_q);
          sel_q   <= '0;
          tx_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done             = done_q;
  assign err              = err_q;
  assign rsp_data         = rsp_q;
  assign busy             = (state_q != IDLE);
  assign spi_start        = start_q;
  assign spi_slave_select = sel_q;
  assign spi_tx_data      = tx_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;
  import spi_pkg::*;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_slave;
  logic [23:0] req_data;
  logic [2:0]  done;
  logic [2:0]  err;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        spi_start;
  logic [1:0]  spi_slave_select;
  logic [7:0]  spi_tx_data;
  logic [7:0]  spi_rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int t     = 0;

  spi_txn_arbiter #(.NREQ(NREQ), .BITS(SPI_BITS_DEF), .GUARD(SPI_GUARD_DEF)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_slave        (req_slave),
    .req_data         (req_data),
    .done             (done),
    .err              (err),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .spi_start        (spi_start),
    .spi_slave_select (spi_slave_select),
    .spi_tx_data      (spi_tx_data),
    .spi_rx_data      (spi_rx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic goto(input int n);
    while (t < n) adv();
  endtask

  initial begin
    reset = 1'b1; req = '0; req_slave = '0; req_data = '0; spi_rx_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_sel",   32'(spi_slave_select), 0);
    chk("rst_tx",    32'(spi_tx_data), 0);
    chk("rst_rsp",   32'(rsp_data), 0);
    reset = 1'b0;

    // Single request from requester 0
    t = 0; req_slave[1:0] = 2'd1; req_data[7:0] = 8'hA5; spi_rx_data = 8'h3C; req = 3'b001;
    goto(1);
    chk("b_sel", 32'(spi_slave_select), 1);
    chk("b_tx", 32'(spi_tx_data), 32'hA5);
    chk("b_start0", 32'(spi_start), 0);
    chk("b_busy", 32'(busy), 1);
    goto(2);  chk("b_start1", 32'(spi_start), 1);
    goto(3);  chk("b_start2", 32'(spi_start), 0);
    goto(13); chk("b_done_early", 32'(done), 0);
    goto(14);
    chk("b_done", 32'(done), 32'h1);
    chk("b_rsp", 32'(rsp_data), 32'h3C);
    chk("b_err", 32'(err), 0);
    req = 3'b000;
    goto(15);
    chk("b_done_clr", 32'(done), 0);
    chk("b_idle", 32'(busy), 0);

    // Invalid slave on requester 1 (ptr is 1)
    t = 0; req_slave[3:2] = 2'd0; req = 3'b010;
    goto(1);
    chk("c_err", 32'(err), 32'h2);
    chk("c_start", 32'(spi_start), 0);
    chk("c_busy", 32'(busy), 0);
    chk("c_done", 32'(done), 0);
    req = 3'b000;
    goto(2); chk("c_err_clr", 32'(err), 0);
    goto(3); chk("c_start2", 32'(spi_start), 0);

    // ptr=2: req 101 grants 2, then wraps to 0, then 2 again
    t = 0; req_slave[1:0] = 2'd1; req_slave[5:4] = 2'd3;
    req_data[7:0] = 8'h11; req_data[23:16] = 8'h5A; spi_rx_data = 8'hC3; req = 3'b101;
    goto(1);  chk("d_sel_r2", 32'(spi_slave_select), 3);
    chk("d_tx_r2", 32'(spi_tx_data), 32'h5A);
    goto(14); chk("d_done_r2", 32'(done), 32'h4);
    chk("d_rsp_r2", 32'(rsp_data), 32'hC3);
    goto(15); chk("d_gap", 32'(busy), 0);
    goto(16); chk("d_sel_r0", 32'(spi_slave_select), 1);
    spi_rx_data = 8'hD4;
    goto(28); chk("d_done_early", 32'(done), 0);
    goto(29); chk("d_done_r0", 32'(done), 32'h1);
    chk("d_rsp_r0", 32'(rsp_data), 32'hD4);
    req = 3'b100;
    goto(31); chk("d_sel_r2b", 32'(spi_slave_select), 3);
    goto(44); chk("d_done_r2b", 32'(done), 32'h4);
    req = 3'b000;
    goto(46); chk("d_idle", 32'(busy), 0);

    // All three held from ptr=0: order 0,1,2,0 with 15-cycle spacing
    t = 0; req_slave = {2'd3, 2'd2, 2'd1}; req_data = 24'h332211; spi_rx_data = 8'h5E; req = 3'b111;
    goto(1);  chk("e_sel0", 32'(spi_slave_select), 1);
    goto(14); chk("e_done0", 32'(done), 32'h1);
    goto(16); chk("e_sel1", 32'(spi_slave_select), 2);
    chk("e_tx1", 32'(spi_tx_data), 32'h22);
    goto(29); chk("e_done1", 32'(done), 32'h2);
    goto(31); chk("e_sel2", 32'(spi_slave_select), 3);
    goto(44); chk("e_done2", 32'(done), 32'h4);
    goto(46); chk("e_sel3", 32'(spi_slave_select), 1);
    goto(58); chk("e_done3_early", 32'(done), 0);
    goto(59); chk("e_done3", 32'(done), 32'h1);
    req = 3'b000;
    goto(61); chk("e_idle", 32'(busy), 0);

    // Requester 0 drops req mid-XFER; inputs changed after grant are ignored
    t = 0; req_slave[1:0] = 2'd2; req_data[7:0] = 8'h77; spi_rx_data = 8'h11; req = 3'b001;
    goto(3); req_slave[1:0] = 2'd3; req_data[7:0] = 8'hEE;
    goto(5); chk("f_tx_hold", 32'(spi_tx_data), 32'h77);
    chk("f_sel_hold", 32'(spi_slave_select), 2);
    goto(6); req = 3'b000;
    goto(10); spi_rx_data = 8'h99;
    goto(14); chk("f_done", 32'(done), 32'h1);
    chk("f_rsp", 32'(rsp_data), 32'h99);
    goto(15); chk("f_done_clr", 32'(done), 0);
    goto(17); chk("f_no_regrant", 32'(busy), 0);

    // Reset while counter=4, then a fresh full-latency transaction
    t = 0; req_slave[3:2] = 2'd1; req_data[15:8] = 8'h42; spi_rx_data = 8'h24; req = 3'b010;
    goto(7); chk("g_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("g_rst_busy", 32'(busy), 0);
    chk("g_rst_start", 32'(spi_start), 0);
    chk("g_rst_sel", 32'(spi_slave_select), 0);
    goto(14); chk("g_rst_done", 32'(done), 0);
    reset = 1'b0;
    t = 0;
    goto(2);  chk("g_start", 32'(spi_start), 1);
    goto(13); chk("g_done_early", 32'(done), 0);
    goto(14); chk("g_done", 32'(done), 32'h2);
    chk("g_rsp", 32'(rsp_data), 32'h24);
    req = 3'b000;
    goto(16); chk("g_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
